// File: rtl/line_memory_ctrl.sv
// line_memory_ctrl: cache-line backing memory with programmable access latency and req/ack handshake.
// Define LINE_MEM_OOR_CHECK_EN to flag and suppress accesses whose upper address bits are nonzero.
module line_memory_ctrl #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o
);
  localparam int OFFS  = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic write_q, oor_q, oor_d, accept, fire, unused_addr;
  logic [LINE_W-1:0] mem_q [DEPTH];
  assign accept = state_q == IDLE && enable_i;
  assign fire = state_q == ACK;
  assign unused_addr = ^addr_i;
`ifdef LINE_MEM_OOR_CHECK_EN
  assign oor_d = (addr_i >> (OFFS + IDX_W)) != '0;
`else
  assign oor_d = 1'b0;
`endif
  // ACK is the final latency cycle; the ack pulse itself lands in IDLE so a new request can follow immediately
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (accept) begin
      state_d = LATENCY == 1 ? ACK : WAIT;
      cnt_d = CNT_W'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      state_d = cnt_q == CNT_W'(1) ? ACK : WAIT;
      cnt_d = cnt_q - 1'b1;
    end else if (fire) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ack_o <= 1'b0;
      busy_o <= 1'b0;
      err_o <= 1'b0;
      data_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ack_o <= fire;
      busy_o <= state_d != IDLE;
      err_o <= fire & oor_q;
      if (fire && !write_q) data_o <= oor_q ? '0 : mem_q[idx_q];
    end
  end
  // Memory contents survive reset; only the in-flight write is dropped
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q <= addr_i[OFFS+IDX_W-1:OFFS];
      oor_q <= oor_d;
      write_q <= write_i;
      wdata_q <= data_i;
    end
    if (fire && write_q && !oor_q && !rst_i) mem_q[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_line_memory_ctrl.sv
// tb_line_memory_ctrl: scoreboard bench for line_memory_ctrl at LATENCY 10 and LATENCY 1.
module tb_line_memory_ctrl;
  localparam int LW = 256;
  localparam int AW = 32;
  typedef struct {
    int cyc;
    logic [LW-1:0] data;
    logic err;
  } exp_t;
  localparam logic [LW-1:0] DB = {8{32'hDEADBEEF}};
  localparam logic [LW-1:0] PA = {8{32'h0A0B0C0D}};
  localparam logic [LW-1:0] PB = {8{32'h11223344}};
  localparam logic [LW-1:0] PC = {8{32'hC0FFEE00}};
  logic clk = 1'b0, rst = 1'b1;
  logic en_a = 1'b0, wr_a = 1'b0, en_b = 1'b0, wr_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [LW-1:0] din_a = '0, din_b = '0, data_a, data_b;
  logic ack_a, busy_a, err_a, ack_b, busy_b, err_b;
  int cyc = 0, checks = 0, passes = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_memory_ctrl #(.LATENCY(10)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en_a), .write_i(wr_a), .addr_i(addr_a), .data_i(din_a),
    .ack_o(ack_a), .data_o(data_a), .busy_o(busy_a), .err_o(err_a));
  line_memory_ctrl #(.LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en_b), .write_i(wr_b), .addr_i(addr_b), .data_i(din_b),
    .ack_o(ack_b), .data_o(data_b), .busy_o(busy_b), .err_o(err_b));

  function automatic void chk(input string n, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endfunction

  always @(negedge clk) if (!rst) begin
    if (ack_a) begin
      if (qa.size() == 0) chk("unexpected ack a", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("ack cycle a", cyc, ea.cyc);
        chk("data a", data_a, ea.data);
        chk("err a", err_a, ea.err);
      end
    end
    if (ack_b) begin
      if (qb.size() == 0) chk("unexpected ack b", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("ack cycle b", cyc, eb.cyc);
        chk("data b", data_b, eb.data);
        chk("err b", err_b, eb.err);
      end
    end
  end

  task automatic issue(input bit u, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d,
                       input logic [LW-1:0] ed, input bit ee);
    exp_t e;
    @(negedge clk);
    e.cyc = cyc + 1 + (u ? 1 : 10);
    e.data = ed;
    e.err = ee;
    if (u) begin
      en_b = 1'b1; wr_b = w; addr_b = a; din_b = d; qb.push_back(e);
    end else begin
      en_a = 1'b1; wr_a = w; addr_a = a; din_a = d; qa.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("ack timeout", qa.size() + qb.size(), 0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    chk("idle after ack a", {busy_a, ack_a}, 2'b00);
  endtask

  task automatic run(input bit u, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d,
                     input logic [LW-1:0] ed, input bit ee);
    issue(u, w, a, d, ed, ee);
    @(negedge clk);
    if (u) en_b = 1'b0;
    else begin
      en_a = 1'b0;
      chk("busy wait a", {busy_a, ack_a}, 2'b10);
      repeat (8) begin
        @(negedge clk);
        chk("busy wait a", {busy_a, ack_a}, 2'b10);
      end
    end
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset ack", ack_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset err", err_a, 0);
    chk("reset data", data_a, 0);
    rst = 1'b0;
    run(0, 1, 32'h0, 256'd5, 256'd0, 0);
    run(0, 0, 32'h0, 256'd0, 256'd5, 0);
    run(0, 1, 32'h400, DB, 256'd5, 0);
    run(0, 0, 32'h400, 256'd0, DB, 0);
    run(0, 1, 32'h20, PA, DB, 0);
    issue(0, 1, 32'h20, PB, 256'd0, 0);
    @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort ack", ack_a, 0);
    chk("abort busy", busy_a, 0);
    chk("abort err", err_a, 0);
    chk("abort data", data_a, 0);
    qa.delete();
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run(0, 0, 32'h20, 256'd0, PA, 0);
`ifdef LINE_MEM_OOR_CHECK_EN
    run(0, 0, 32'h4000, 256'd0, 256'd0, 1);
    run(0, 1, 32'h4000, PC, 256'd0, 1);
    run(0, 0, 32'h0, 256'd0, 256'd5, 0);
`else
    run(0, 0, 32'h4000, 256'd0, 256'd5, 0);
    run(0, 1, 32'h4000, PC, 256'd5, 0);
    run(0, 0, 32'h0, 256'd0, PC, 0);
`endif
    run(1, 1, 32'h0, 256'd7, 256'd0, 0);
    issue(1, 0, 32'h0, 256'd0, 256'd7, 0);
    ea.cyc = qb[0].cyc + 2;
    ea.data = 256'd7;
    ea.err = 1'b0;
    qb.push_back(ea);
    repeat (3) @(negedge clk);
    en_b = 1'b0;
    wait_done();
    chk("idle after ack b", {busy_b, ack_b}, 2'b00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
